// File: rtl/instruction_fetcher.sv
// Fetch stage ahead of the direct-mapped I-cache: PC lookup, miss refill from memory, decode handoff.
// Optional macro IFETCH_BYPASS_EN forwards the refilled word straight to decode on mem_done.
module instruction_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   output logic [31:0] ic_addr,
   output logic        ic_wr,
   output logic [31:0] ic_value,
   input  logic        ic_hit,
   input  logic [31:0] ic_result,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   // state    | meaning
   // ST_FETCH | look up pc in the cache, hand hits to decode
   // ST_MISS  | memory read outstanding for r_miss_addr
   // ST_FILL  | write refilled word into the cache at r_miss_addr
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_MISS  = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_miss_addr;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic        r_mem_req;
   logic [31:0] r_mem_addr;
   logic        r_ic_wr;
   logic [31:0] r_ic_value;
`ifdef IFETCH_BYPASS_EN
   logic        r_stale;
`endif

   logic        w_slot_free;
   logic [31:0] w_redirect_pc;

   assign w_slot_free   = !r_inst_valid || inst_ready;
   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

   assign ic_addr    = (r_state == ST_FILL) ? r_miss_addr : r_pc;
   assign ic_wr      = r_ic_wr;
   assign ic_value   = r_ic_value;
   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign inst_valid = r_inst_valid;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_miss_addr  <= 32'h0;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0;
         r_inst_pc    <= 32'h0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_ic_wr      <= 1'b0;
         r_ic_value   <= 32'h0;
`ifdef IFETCH_BYPASS_EN
         r_stale      <= 1'b0;
`endif
      end else if (rdy_in) begin
         if (r_inst_valid && inst_ready)
            r_inst_valid <= 1'b0;

         case (r_state)
            ST_FETCH: begin
               if (!redirect) begin
                  if (ic_hit) begin
                     if (w_slot_free) begin
                        r_inst       <= ic_result;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + 32'd4;
                     end
                  end else begin
                     r_miss_addr <= r_pc;
                     r_mem_addr  <= r_pc;
                     r_mem_req   <= 1'b1;
                     r_state     <= ST_MISS;
                  end
               end
            end

            ST_MISS: begin
               // The outstanding read cannot be cancelled; a redirect only marks it stale.
               if (mem_done) begin
                  r_mem_req  <= 1'b0;
                  r_ic_value <= mem_data;
                  r_ic_wr    <= 1'b1;
                  r_state    <= ST_FILL;
`ifdef IFETCH_BYPASS_EN
                  if (!r_stale && !redirect && w_slot_free) begin
                     r_inst       <= mem_data;
                     r_inst_pc    <= r_miss_addr;
                     r_inst_valid <= 1'b1;
                     r_pc         <= r_miss_addr + 32'd4;
                  end
`endif
               end
`ifdef IFETCH_BYPASS_EN
               if (redirect)
                  r_stale <= 1'b1;
`endif
            end

            ST_FILL: begin
               r_ic_wr <= 1'b0;
               r_state <= ST_FETCH;
`ifdef IFETCH_BYPASS_EN
               r_stale <= 1'b0;
`endif
            end

            default: begin
               r_ic_wr <= 1'b0;
               r_state <= ST_FETCH;
            end
         endcase

         // Redirect overrides any slot load or pc advance made above in the same cycle.
         if (redirect) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a behavioural cache and fixed-latency memory model.
// Expectations are for the default build (IFETCH_BYPASS_EN undefined).
module tb_instruction_fetcher;

   localparam int MEM_LAT = 3;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [31:0] ic_addr;
   logic        ic_wr;
   logic [31:0] ic_value;
   logic        ic_hit;
   logic [31:0] ic_result;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int n_chk  = 0;
   int n_fail = 0;

   instruction_fetcher #(.RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .ic_addr(ic_addr), .ic_wr(ic_wr), .ic_value(ic_value),
      .ic_hit(ic_hit), .ic_result(ic_result),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   always #5 clk_in = ~clk_in;

   // behavioural cache: small fully associative table, combinational lookup
   logic        c_v [16];
   logic [31:0] c_a [16];
   logic [31:0] c_d [16];
   int          c_ptr = 0;
   logic        pl_we = 1'b0;
   logic        pl_clr = 1'b0;
   logic [31:0] pl_addr = 32'h0;
   logic [31:0] pl_data = 32'h0;

   always_comb begin
      ic_hit    = 1'b0;
      ic_result = 32'h0;
      for (int i = 0; i < 16; i++) begin
         if (c_v[i] && c_a[i] == ic_addr) begin
            ic_hit    = 1'b1;
            ic_result = c_d[i];
         end
      end
   end

   always @(posedge clk_in) begin : cache_wr
      logic [31:0] wa;
      logic [31:0] wd;
      int          slot;
      if (pl_clr) begin
         for (int i = 0; i < 16; i++) c_v[i] <= 1'b0;
         c_ptr <= 0;
      end else if (ic_wr || pl_we) begin
         wa   = ic_wr ? ic_addr : pl_addr;
         wd   = ic_wr ? ic_value : pl_data;
         slot = c_ptr;
         for (int i = 0; i < 16; i++)
            if (c_v[i] && c_a[i] == wa) slot = i;
         c_v[slot] <= 1'b1;
         c_a[slot] <= wa;
         c_d[slot] <= wd;
         if (slot == c_ptr) c_ptr <= c_ptr + 1;
      end
   end

   // memory: mem_done pulses so that the DUT samples it MEM_LAT edges after mem_req rose
   int mem_cnt;
   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_done <= 1'b0;
         mem_data <= 32'h0;
         mem_cnt  <= 0;
      end else begin
         mem_done <= 1'b0;
         if (rdy_in && mem_req && !mem_done) begin
            if (mem_cnt == MEM_LAT - 2) begin
               mem_done <= 1'b1;
               mem_data <= mem_addr + 32'h13;
               mem_cnt  <= 0;
            end else begin
               mem_cnt <= mem_cnt + 1;
            end
         end
      end
   end

   function automatic logic [31:0] cdat(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic preload(input logic [31:0] a);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = cdat(a);
      tick();
      pl_we   = 1'b0;
   endtask

   int          wr_cnt;
   logic [31:0] wr_addr;
   logic [31:0] wr_val;

   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
         if (ic_wr) begin
            wr_cnt++;
            wr_addr = ic_addr;
            wr_val  = ic_value;
         end
      end while (!inst_valid && n < max);
   endtask

   initial begin
      int          n;
      logic        s_valid;
      logic [31:0] s_pc, s_inst, s_addr;
      logic        s_req;

      rst_n_in    = 1'b0;
      rdy_in      = 1'b1;
      inst_ready  = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      pl_clr      = 1'b1;
      tick();
      pl_clr      = 1'b0;
      preload(32'h0);
      preload(32'h4);
      preload(32'h8);
      preload(32'hC);
      preload(32'hFFFF_FFFC);

      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_ic_wr", {31'h0, ic_wr}, 32'h0);
      chk("rst_ic_value", ic_value, 32'h0);
      chk("rst_ic_addr", ic_addr, 32'h0);

      // streaming hits, one per cycle
      rst_n_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hit_valid", {31'h0, inst_valid}, 32'h1);
         chk("hit_pc", inst_pc, 32'(i * 4));
         chk("hit_inst", inst, cdat(32'(i * 4)));
      end

      // redirect while the slot is being consumed: nothing new loaded that cycle
      redirect = 1'b1; redirect_pc = 32'h7;
      tick();
      redirect = 1'b0;
      chk("redir_drop_valid", {31'h0, inst_valid}, 32'h0);
      chk("redir_ic_addr", ic_addr, 32'h4);
      tick();
      chk("redir_next_pc", inst_pc, 32'h4);
      chk("redir_next_valid", {31'h0, inst_valid}, 32'h1);

      // back-pressure for 5 cycles
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {31'h0, inst_valid}, 32'h1);
         chk("stall_pc", inst_pc, 32'h4);
         chk("stall_inst", inst, cdat(32'h4));
         chk("stall_lookup", ic_addr, 32'h8);
      end
      inst_ready = 1'b1;
      tick();
      chk("release_pc0", inst_pc, 32'h8);
      tick();
      chk("release_pc1", inst_pc, 32'hC);

      // miss at 0x40, redirected away mid-miss
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      chk("to40_valid", {31'h0, inst_valid}, 32'h0);
      chk("to40_ic_addr", ic_addr, 32'h40);
      chk("to40_mem_req", {31'h0, mem_req}, 32'h0);
      tick();
      chk("miss40_req", {31'h0, mem_req}, 32'h1);
      chk("miss40_addr", mem_addr, 32'h40);
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      chk("miss40_req_held", {31'h0, mem_req}, 32'h1);
      chk("miss40_addr_held", mem_addr, 32'h40);
      tick();
      chk("miss40_req_held2", {31'h0, mem_req}, 32'h1);
      tick();
      chk("fill40_wr", {31'h0, ic_wr}, 32'h1);
      chk("fill40_addr", ic_addr, 32'h40);
      chk("fill40_value", ic_value, 32'h53);
      chk("fill40_req_off", {31'h0, mem_req}, 32'h0);
      chk("fill40_no_deliver", {31'h0, inst_valid}, 32'h0);
      tick();
      chk("after_fill_wr", {31'h0, ic_wr}, 32'h0);
      chk("after_fill_ic_addr", ic_addr, 32'h100);
      chk("after_fill_valid", {31'h0, inst_valid}, 32'h0);

      // 0x100 is cold: 1 cycle to issue, then 5-cycle miss penalty
      wr_cnt = 0;
      wait_valid(20, n);
      chk("t100_cycles", 32'(n), 32'd6);
      chk("t100_pc", inst_pc, 32'h100);
      chk("t100_inst", inst, 32'h113);
      chk("t100_wr_cnt", 32'(wr_cnt), 32'd1);

      // wrap at top of address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      chk("wrap_ic_addr", ic_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wrap_inst", inst, cdat(32'hFFFF_FFFC));
      chk("wrap_next_lookup", ic_addr, 32'h0);

      // freeze with rdy_in=0
      rdy_in  = 1'b0;
      s_valid = inst_valid; s_pc = inst_pc; s_inst = inst; s_addr = ic_addr; s_req = mem_req;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_valid", {31'h0, inst_valid}, {31'h0, s_valid});
         chk("frz_pc", inst_pc, s_pc);
         chk("frz_inst", inst, s_inst);
         chk("frz_ic_addr", ic_addr, s_addr);
         chk("frz_mem_req", {31'h0, mem_req}, {31'h0, s_req});
      end
      rdy_in = 1'b1;
      tick();
      chk("resume_pc0", inst_pc, 32'h0);
      tick();
      chk("resume_pc1", inst_pc, 32'h4);

      // cold miss at 0x0 after reset with empty cache
      rst_n_in = 1'b0;
      pl_clr   = 1'b1;
      #1;
      chk("rst2_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst2_pc", ic_addr, 32'h0);
      tick();
      pl_clr = 1'b0;
      tick();
      rst_n_in = 1'b1;
      tick();
      chk("cold_req", {31'h0, mem_req}, 32'h1);
      chk("cold_addr", mem_addr, 32'h0);
      wr_cnt = 0; wr_addr = 32'hDEAD_BEEF; wr_val = 32'hDEAD_BEEF;
      wait_valid(20, n);
      chk("cold_cycles", 32'(n), 32'd5);
      chk("cold_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("cold_wr_addr", wr_addr, 32'h0);
      chk("cold_wr_val", wr_val, 32'h13);
      chk("cold_inst", inst, 32'h13);
      chk("cold_pc", inst_pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
